// File: rtl/conv_result_sink_pkg.sv
// conv_result_sink_pkg
//   Shared geometry and encodings for the convolution result sink.
//   The producer and the sink both derive the result-map size from the
//   same out_size() helper, so they cannot disagree on frame length.
//   Contents: base parameters, derived sizes (OUT_SIZE, RES_SIDE, DEPTH,
//   AW, CW) and the sink FSM state type.
package conv_result_sink_pkg;

  localparam int DW          = 16;
  localparam int KERNEL_SIZE = 3;
  localparam int FM_SIZE     = 8;
  localparam int PADDING     = 0;
  localparam int STRIDE      = 1;
  localparam int MAXPOOL     = 1;

  function automatic int out_size(input int fm, input int k, input int p, input int s);
    return ((fm - k + 2 * p) / s) + 1;
  endfunction

  localparam int OUT_SIZE = out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE);
  localparam int RES_SIDE = (MAXPOOL != 0) ? OUT_SIZE / 2 : OUT_SIZE;
  localparam int DEPTH    = RES_SIDE * RES_SIDE;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so the count can hold DEPTH itself.
  localparam int CW       = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } sink_state_t;

endpackage

// File: rtl/conv_result_sink_ram.sv
// result_ram
//   Simple dual-port result buffer, DW x DEPTH. One write port, one
//   registered read port. A read and a write to the same address in the
//   same cycle return the old contents (read-first). Contents are not
//   reset; only the read output register is.
//   Ports:
//     i_clk, i_rst           clock, synchronous active-high reset (read reg only)
//     i_wr_en/addr/data      write port
//     i_rd_en/addr           read request; o_rd_data updates the next cycle
//     o_rd_data              registered read data, holds when i_rd_en is 0
module result_ram
  import conv_result_sink_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conv_result_sink.sv
// conv_result_sink
//   Receiving end of the convolution result stream. Captures each strobed
//   word into the result buffer in raster order, tracks frame completion,
//   flags protocol errors and serves a 1-cycle registered read port.
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_en, i_data        result word strobe and data
//     i_src_done          producer finished (held high afterwards)
//     i_clr               start a new frame (buffer contents kept)
//     i_rd_req, i_rd_addr read request / address
//     o_rd_valid/data/err read response, one cycle after i_rd_req
//     o_wr_cnt            words captured in the current frame
//     o_frame_done        one-cycle pulse on frame completion
//     o_full              buffer holds a complete frame
//     o_overflow          sticky: write arrived after the frame was closed
//     o_underrun          sticky: producer done before DEPTH words
//     o_dbg_state         current FSM state (sink_state_t encoding)
//
//   Stream handshake: i_en is a valid-only strobe with no ready/backpressure;
//   every cycle with i_en high delivers exactly one word, which is either
//   captured or dropped (by i_clr, or because the frame is already closed).
module conv_result_sink
  import conv_result_sink_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  input  logic          i_src_done,
  input  logic          i_clr,
  input  logic          i_rd_req,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_err,
  output logic [AW:0]   o_wr_cnt,
  output logic          o_frame_done,
  output logic          o_full,
  output logic          o_overflow,
  output logic          o_underrun,
  output logic [1:0]    o_dbg_state
);

  sink_state_t   r_state, w_state_next;
  logic [CW-1:0] r_wr_cnt;
  logic          r_frame_done, r_full, r_overflow, r_underrun;
  logic          r_rd_valid, r_rd_oor;

  logic [CW-1:0] w_cnt_inc;
  logic          w_wr_en, w_complete, w_underrun_evt, w_overflow_evt;
  logic          w_rd_in_range;
  logic [DW-1:0] w_ram_rd_data;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; i_clr overrides everything else.
  always_comb begin
    w_state_next = r_state;
    if (i_clr)                             w_state_next = ST_IDLE;
    else if (w_complete || w_underrun_evt) w_state_next = ST_DONE;
    else if (r_state == ST_IDLE && i_en)   w_state_next = ST_CAPTURE;
  end

  // Output / event decode. A simultaneous write is taken before the
  // underrun check, so a write that completes the frame masks i_src_done.
  always_comb begin
    w_cnt_inc      = r_wr_cnt + CW'(1);
    w_wr_en        = 1'b0;
    w_complete     = 1'b0;
    w_underrun_evt = 1'b0;
    w_overflow_evt = 1'b0;
    if (!i_clr) begin
      case (r_state)
        ST_IDLE: begin
          w_wr_en    = i_en;
          w_complete = i_en && (w_cnt_inc == CW'(DEPTH));
        end
        ST_CAPTURE: begin
          w_wr_en        = i_en;
          w_complete     = i_en && (w_cnt_inc == CW'(DEPTH));
          w_underrun_evt = i_src_done && !w_complete;
        end
        ST_DONE: begin
          w_overflow_evt = i_en;
        end
        default: ;
      endcase
    end
  end

  // Frame counters and status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_cnt     <= '0;
      r_full       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= w_complete;
      if (i_clr) begin
        r_wr_cnt <= '0;
        r_full   <= 1'b0;
      end else begin
        if (w_wr_en)    r_wr_cnt <= w_cnt_inc;
        if (w_complete) r_full   <= 1'b1;
      end
      if (w_overflow_evt) r_overflow <= 1'b1;
      if (w_underrun_evt) r_underrun <= 1'b1;
    end
  end

  // Compare at CW bits so DEPTH == 2**AW does not wrap to zero.
  assign w_rd_in_range = ({1'b0, i_rd_addr} < CW'(DEPTH));

  // r_rd_oor only changes on a request so o_rd_data holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_oor   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_req;
      if (i_rd_req) r_rd_oor <= !w_rd_in_range;
    end
  end

  result_ram u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_cnt[AW-1:0]),
    .i_wr_data (i_data),
    .i_rd_en   (i_rd_req && w_rd_in_range),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (w_ram_rd_data)
  );

  assign o_rd_valid   = r_rd_valid;
  assign o_rd_err     = r_rd_valid & r_rd_oor;
  assign o_rd_data    = r_rd_oor ? '0 : w_ram_rd_data;
  assign o_wr_cnt     = r_wr_cnt;
  assign o_frame_done = r_frame_done;
  assign o_full       = r_full;
  assign o_overflow   = r_overflow;
  assign o_underrun   = r_underrun;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/conv_result_sink.md
Name: conv_result_sink

Overview:
- Receiving end of the convolution block's result stream: captures each `o_en`/`o_conv_result` word into an on-chip result buffer, in arrival (raster) order.
- Tracks frame completion and flags protocol errors (extra words, early producer done).
- Offers a registered random-access read port so the next layer or the test harness can fetch the finished output feature map.

Parameters:
- DW, `DW (16), result word width, signed.
- KERNEL_SIZE, `KERNEL_SIZE (3), kernel side.
- FM_SIZE, `FM_SIZE (8), input feature-map side.
- PADDING, `PADDING (0), padding per edge.
- STRIDE, `STRIDE (1), convolution stride.
- MAXPOOL, `MAXPOOL (1), 1 = producer emits 2x2-pooled results.
- OUT_SIZE, localparam, ((FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE)+1.
- RES_SIDE, localparam, MAXPOOL ? OUT_SIZE/2 : OUT_SIZE.
- DEPTH, localparam, RES_SIDE**2 (number of words per frame).
- AW, localparam, max($clog2(DEPTH),1).

Ports:
- i_clk  in  1  clock; everything is on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_en  in  1  write strobe; connects to the conv block o_en.
- i_data  in  DW  signed result word; connects to o_conv_result.
- i_src_done  in  1  producer finished sending; connects to o_done.
- i_clr  in  1  start a new frame; buffer contents are kept.
- i_rd_req  in  1  read request.
- i_rd_addr  in  AW  read address.
- o_rd_valid  out  1  read data valid, 1 cycle after i_rd_req.
- o_rd_data  out  DW  read data.
- o_rd_err  out  1  qualifies o_rd_valid: the address was >= DEPTH.
- o_wr_cnt  out  AW+1  number of words captured in the current frame.
- o_frame_done  out  1  one-cycle pulse when the frame completes.
- o_full  out  1  level: the buffer holds a complete frame.
- o_overflow  out  1  sticky: a write arrived while in DONE.
- o_underrun  out  1  sticky: producer signalled done before DEPTH words arrived.

Behaviour:
- Reset values: every output is 0; FSM goes to IDLE; write pointer is 0. Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - i_en: write i_data at address 0, wr_cnt=1, go to CAPTURE.
  - If DEPTH==1, go straight to DONE instead.
- CAPTURE:
  - Each i_en writes buf[wr_cnt] and increments wr_cnt.
  - The write that makes wr_cnt==DEPTH moves to DONE. o_frame_done pulses and o_full rises in the cycle after that write.
- CAPTURE, i_src_done with wr_cnt<DEPTH and no i_en in the same cycle:
  - Set o_underrun, go to DONE; o_full stays 0; no o_frame_done pulse.
- CAPTURE, i_src_done together with i_en: the write is taken first, then the underrun check uses the updated count.
- i_src_done in IDLE or DONE: ignored. The producer holds o_done high after finishing, so it must not retrigger.
- DONE:
  - i_en: the write is dropped and o_overflow is set.
  - i_clr: go to IDLE; wr_cnt=0; o_full=0. Sticky flags are kept and cleared only by i_rst.
- i_clr in IDLE or CAPTURE: return to IDLE, wr_cnt=0, pending partial frame discarded.
- i_clr has priority over i_en in the same cycle; that write is dropped.
- Read port:
  - Latency is exactly 1 cycle, in any state. o_rd_valid = i_rd_req delayed by one cycle.
  - o_rd_data = buf[i_rd_addr] when the address is < DEPTH.
  - Otherwise o_rd_data = 0 and o_rd_err = 1 (o_rd_err is only meaningful while o_rd_valid is 1).
  - Same-cycle read and write to the same address returns the old data (read-first).
  - When i_rd_req is 0, o_rd_valid = 0 and o_rd_data holds its last value.
- Mid-operation i_rst: returns to the reset state next cycle; partial frames are lost.
- Width: wr_cnt is AW+1 bits so the value DEPTH is representable. The buffer is inferred block or distributed RAM: single write port, single registered read port.

Decomposition:
- Shared package / global.v holds:
  - `DW, `KERNEL_SIZE, `FM_SIZE, `PADDING, `STRIDE, `MAXPOOL.
  - An OUT_SIZE macro expression, so producer and sink cannot disagree on geometry.
  - FSM state encodings (IDLE=0, CAPTURE=1, DONE=2).
- One sub-module: result_ram, a simple dual-port RAM (DW x DEPTH) with a read-first registered read.
- FSM, counters and flags stay in the top level.

Test Plan:
All scenarios use FM_SIZE=8, K=3, P=0, S=1, MAXPOOL=1, giving OUT_SIZE=6, RES_SIDE=3, DEPTH=9.
- Nominal frame: 9 i_en pulses with data 10..18, gaps of 0-3 cycles → o_frame_done pulses once, o_full=1, o_wr_cnt=9; reads of addr 0..8 return 10..18 one cycle after each request, o_rd_err=0.
- Back-to-back writes with i_src_done held high from the 9th write onward → no underrun and no second frame; i_clr → o_full=0, o_wr_cnt=0; a new frame of data 100..108 reads back correctly.
- Overflow: a 10th i_en with data 99 after DONE → o_overflow=1, addr 8 still reads 18; o_overflow persists after i_clr and clears only on i_rst.
- Underrun: 5 writes, then i_src_done alone → o_underrun=1, state DONE, o_full=0, o_wr_cnt=5, no o_frame_done pulse.
- Read corner cases:
  - Read addr 12 → o_rd_valid=1, o_rd_err=1, data 0.
  - Read addr 3 in the same cycle it is written with 77 → returns the old value; re-reading the next cycle returns 77.
- Reset mid-capture: after 4 writes, 1-cycle i_rst → all outputs 0; a full 9-word frame afterwards completes normally.
